// File: rtl/riscv_pkg.sv
// Shared constants and the IF/ID register layout for the five-stage RISC-V pipeline.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          RS1_MSB   = 19;
  localparam int          RS1_LSB   = 15;
  localparam int          RS2_MSB   = 24;
  localparam int          RS2_LSB   = 20;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

endpackage

// File: rtl/sat_counter.sv
// Counter that increments on inc and sticks at all-ones instead of wrapping.
module sat_counter
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  output logic [XLEN-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {XLEN{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register and fetch/stall debug counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [4:0]  Rs1_D,
  output logic [4:0]  Rs2_D,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
);

  import riscv_pkg::*;

  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

  logic [31:0] pc_plus4_f;
  logic        kill_d;
  logic        load_d;
  logic        hold_d;
  ifid_t       ifid_q;

  assign pc_plus4_f = PCF + 32'd4;
  assign kill_d     = FlushD | PCSrcE;
  assign load_d     = !kill_d && !StallD;
  assign hold_d     = !kill_d && StallD;

  // A redirect wins over StallF: whatever is being held is on the wrong path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      PCF <= RESET_PC;
    end else if (PCSrcE) begin
      PCF <= {PCTargetE[31:2], 2'b00};
    end else if (!StallF) begin
      PCF <= pc_plus4_f;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || kill_d) begin
      ifid_q <= BUBBLE;
    end else if (load_d) begin
      ifid_q <= '{instr: InstrF, pc: PCF, pc_plus4: pc_plus4_f, valid: 1'b1};
    end
  end

  assign InstrD   = ifid_q.instr;
  assign PCD      = ifid_q.pc;
  assign PCPlus4D = ifid_q.pc_plus4;
  assign ValidD   = ifid_q.valid;

  // Bubbles report x0 sources so they never trigger a load-use stall.
  assign Rs1_D = ifid_q.valid ? ifid_q.instr[RS1_MSB:RS1_LSB] : 5'd0;
  assign Rs2_D = ifid_q.valid ? ifid_q.instr[RS2_MSB:RS2_LSB] : 5'd0;

  sat_counter u_fetch_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (load_d),
    .count (FetchCount)
  );

  sat_counter u_stall_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (hold_d),
    .count (StallCount)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: PC sequencing, IF/ID stall/flush/redirect, wrap and counters.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE, InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D, FetchCount, StallCount;
  logic        ValidD;
  logic [4:0]  Rs1_D, Rs2_D;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .InstrF     (InstrF),
    .PCF        (PCF),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .Rs1_D      (Rs1_D),
    .Rs2_D      (Rs2_D),
    .FetchCount (FetchCount),
    .StallCount (StallCount)
  );

  always #5 clk = ~clk;

  // PC-indexed instruction: rs2 = pc[6:2], rs1 = ~pc[6:2], rd = x1, opcode OP.
  function automatic logic [31:0] instr_at(input logic [31:0] pc);
    return {7'h00, pc[6:2], ~pc[6:2], 3'b000, 5'd1, 7'h33};
  endfunction

  always_comb InstrF = instr_at(PCF);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_ctl();
    tick();
    tick();
    n_checks++; if (PCF !== 32'h0) begin n_fail++; $display("FAIL reset_pcf: got %h want %h", PCF, 32'h0); end
    n_checks++; if (InstrD !== 32'h13) begin n_fail++; $display("FAIL reset_instr: got %h want %h", InstrD, 32'h13); end
    n_checks++; if ({PCD, PCPlus4D} !== 64'h0) begin n_fail++; $display("FAIL reset_pcd: got %h %h want 0 0", PCD, PCPlus4D); end
    n_checks++; if (ValidD !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ValidD); end
    n_checks++; if ({FetchCount, StallCount} !== 64'h0) begin n_fail++; $display("FAIL reset_counts: got %h %h want 0 0", FetchCount, StallCount); end
    n_checks++; if ({Rs1_D, Rs2_D} !== 10'h0) begin n_fail++; $display("FAIL reset_rs: got %h %h want 0 0", Rs1_D, Rs2_D); end
  endtask

  task automatic test_free_run();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (PCF !== 32'(4 * (k + 1))) begin n_fail++; $display("FAIL run_pcf[%0d]: got %h want %h", k, PCF, 32'(4 * (k + 1))); end
      n_checks++; if (PCD !== 32'(4 * k) || PCPlus4D !== 32'(4 * k + 4)) begin n_fail++; $display("FAIL run_pcd[%0d]: got %h %h want %h %h", k, PCD, PCPlus4D, 32'(4 * k), 32'(4 * k + 4)); end
      n_checks++; if (InstrD !== instr_at(32'(4 * k)) || ValidD !== 1'b1) begin n_fail++; $display("FAIL run_instr[%0d]: got %h v%b want %h v1", k, InstrD, ValidD, instr_at(32'(4 * k))); end
      n_checks++; if (FetchCount !== 32'(k + 1)) begin n_fail++; $display("FAIL run_fcount[%0d]: got %0d want %0d", k, FetchCount, k + 1); end
    end
  endtask

  task automatic test_stall();
    StallF = 1'b1; StallD = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      n_checks++; if (PCF !== 32'h10) begin n_fail++; $display("FAIL stall_pcf[%0d]: got %h want %h", k, PCF, 32'h10); end
      n_checks++; if (PCD !== 32'hC || InstrD !== instr_at(32'hC)) begin n_fail++; $display("FAIL stall_ifid[%0d]: got %h %h want %h %h", k, PCD, InstrD, 32'hC, instr_at(32'hC)); end
      n_checks++; if (StallCount !== 32'(k)) begin n_fail++; $display("FAIL stall_scount[%0d]: got %0d want %0d", k, StallCount, k); end
    end
    clear_ctl();
    tick();
    n_checks++; if (PCF !== 32'h14 || PCD !== 32'h10) begin n_fail++; $display("FAIL stall_resume: got %h %h want %h %h", PCF, PCD, 32'h14, 32'h10); end
    n_checks++; if (StallCount !== 32'd2 || FetchCount !== 32'd5) begin n_fail++; $display("FAIL stall_counts: got %0d %0d want 2 5", StallCount, FetchCount); end
  endtask

  task automatic test_redirect_stall();
    StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h203;
    tick();
    n_checks++; if (PCF !== 32'h200) begin n_fail++; $display("FAIL redir_pcf: got %h want %h", PCF, 32'h200); end
    n_checks++; if (InstrD !== 32'h13 || ValidD !== 1'b0 || PCD !== 32'h0) begin n_fail++; $display("FAIL redir_bubble: got %h v%b pc %h want 00000013 v0 pc 0", InstrD, ValidD, PCD); end
    n_checks++; if ({Rs1_D, Rs2_D} !== 10'h0) begin n_fail++; $display("FAIL redir_rs: got %h %h want 0 0", Rs1_D, Rs2_D); end
    n_checks++; if (FetchCount !== 32'd5 || StallCount !== 32'd2) begin n_fail++; $display("FAIL redir_counts: got %0d %0d want 5 2", FetchCount, StallCount); end
    clear_ctl();
    tick();
    n_checks++; if (PCD !== 32'h200 || InstrD !== instr_at(32'h200) || ValidD !== 1'b1) begin n_fail++; $display("FAIL redir_target: got %h %h v%b want %h %h v1", PCD, InstrD, ValidD, 32'h200, instr_at(32'h200)); end
    n_checks++; if (PCF !== 32'h204 || FetchCount !== 32'd6) begin n_fail++; $display("FAIL redir_next: got %h %0d want %h 6", PCF, FetchCount, 32'h204); end
  endtask

  task automatic test_flush_stall();
    StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1;
    tick();
    n_checks++; if (InstrD !== 32'h13 || ValidD !== 1'b0) begin n_fail++; $display("FAIL flush_bubble: got %h v%b want 00000013 v0", InstrD, ValidD); end
    n_checks++; if ({Rs1_D, Rs2_D} !== 10'h0) begin n_fail++; $display("FAIL flush_rs: got %h %h want 0 0", Rs1_D, Rs2_D); end
    n_checks++; if (StallCount !== 32'd2 || PCF !== 32'h204) begin n_fail++; $display("FAIL flush_hold: got %0d %h want 2 %h", StallCount, PCF, 32'h204); end
    clear_ctl();
    tick();
    n_checks++; if (PCD !== 32'h204 || PCF !== 32'h208 || FetchCount !== 32'd7) begin n_fail++; $display("FAIL flush_resume: got %h %h %0d want %h %h 7", PCD, PCF, FetchCount, 32'h204, 32'h208); end
    n_checks++; if (Rs1_D !== 5'h1E || Rs2_D !== 5'h01) begin n_fail++; $display("FAIL flush_rs_valid: got %h %h want 1e 01", Rs1_D, Rs2_D); end
  endtask

  task automatic test_mismatched_stall();
    StallF = 1'b1; StallD = 1'b0;
    tick();
    n_checks++; if (PCF !== 32'h208 || PCD !== 32'h208 || FetchCount !== 32'd8) begin n_fail++; $display("FAIL dup_fetch: got %h %h %0d want %h %h 8", PCF, PCD, FetchCount, 32'h208, 32'h208); end
    StallF = 1'b0; StallD = 1'b1;
    tick();
    n_checks++; if (PCF !== 32'h20C || PCD !== 32'h208) begin n_fail++; $display("FAIL drop_fetch: got %h %h want %h %h", PCF, PCD, 32'h20C, 32'h208); end
    n_checks++; if (StallCount !== 32'd3 || FetchCount !== 32'd8) begin n_fail++; $display("FAIL drop_counts: got %0d %0d want 3 8", StallCount, FetchCount); end
    clear_ctl();
  endtask

  task automatic test_pc_wrap();
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    tick();
    n_checks++; if (PCF !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_target: got %h want %h", PCF, 32'hFFFF_FFFC); end
    clear_ctl();
    tick();
    n_checks++; if (PCF !== 32'h0) begin n_fail++; $display("FAIL wrap_pcf: got %h want %h", PCF, 32'h0); end
    n_checks++; if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0) begin n_fail++; $display("FAIL wrap_pcd: got %h %h want %h %h", PCD, PCPlus4D, 32'hFFFF_FFFC, 32'h0); end
  endtask

  task automatic test_mid_reset();
    StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h400;
    tick();
    StallF = 1'b1; StallD = 1'b1; FlushD = 1'b0; PCSrcE = 1'b1;
    rst = 1'b0;
    tick();
    n_checks++; if (PCF !== 32'h0 || InstrD !== 32'h13 || ValidD !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got %h %h v%b want 0 00000013 v0", PCF, InstrD, ValidD); end
    n_checks++; if ({FetchCount, StallCount} !== 64'h0 || {PCD, PCPlus4D} !== 64'h0) begin n_fail++; $display("FAIL midrst_regs: got %h %h %h %h want 0", FetchCount, StallCount, PCD, PCPlus4D); end
    rst = 1'b1;
    clear_ctl();
  endtask

  task automatic test_saturation();
    force dut.u_fetch_count.count = 32'hFFFF_FFFE;
    #1;
    release dut.u_fetch_count.count;
    tick();
    n_checks++; if (FetchCount !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_first: got %h want %h", FetchCount, 32'hFFFF_FFFF); end
    tick();
    tick();
    n_checks++; if (FetchCount !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_hold: got %h want %h", FetchCount, 32'hFFFF_FFFF); end
    n_checks++; if (PCF !== 32'hC || PCD !== 32'h8) begin n_fail++; $display("FAIL sat_pc: got %h %h want %h %h", PCF, PCD, 32'hC, 32'h8); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_flush_stall();
    test_mismatched_stall();
    test_pc_wrap();
    test_mid_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
